fetch_decode: RTL

FETCH_DECODE -- requirements
Module: fetch_decode

---
 rtl/fetch_decode_pkg.sv | 36 +++
 rtl/fetch_decode_decoder.sv | 63 ++++++
 rtl/fetch_decode.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/fetch_decode_pkg.sv
// fetch_decode_pkg
// Shared definitions for the fetch/decode sequencer:
//   state_t      - sequencer state encoding
//   OP_*         - 4-bit opcode values (IR[15:12])
//   FN_*         - 6-bit R-type function values (IR[5:0])
//   sign_ext8    - sign-extends an 8-bit immediate to 16 bits
package fetch_decode_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_IF   = 3'd1,
        ST_ID   = 3'd2,
        ST_EX   = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } state_t;

    localparam logic [3:0] OP_BNE   = 4'd0;
    localparam logic [3:0] OP_BEQ   = 4'd1;
    localparam logic [3:0] OP_BGZ   = 4'd2;
    localparam logic [3:0] OP_BLZ   = 4'd3;
    localparam logic [3:0] OP_ADI   = 4'd4;
    localparam logic [3:0] OP_ORI   = 4'd5;
    localparam logic [3:0] OP_LHI   = 4'd6;
    localparam logic [3:0] OP_JMP   = 4'd9;
    localparam logic [3:0] OP_JAL   = 4'd10;
    localparam logic [3:0] OP_RTYPE = 4'd15;

    localparam logic [5:0] FN_WWD = 6'd28;
    localparam logic [5:0] FN_HLT = 6'd29;

    function automatic logic [15:0] sign_ext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

endpackage

// File: rtl/fetch_decode_decoder.sv
// instr_decoder
// Purely combinational field extraction from the instruction register.
// Ports:
//   ir         in  16  latched instruction word
//   opcode     out 4   IR[15:12]
//   read1      out 2   IR[11:10]
//   read2      out 2   IR[9:8]
//   func       out 6   IR[5:0]
//   imm_ext    out 16  sign-extended IR[7:0]
//   write_reg  out 2   destination register select
//   wb_elig    out 1   instruction writes the register file in WB
//   is_branch  out 1   conditional branch (opcodes 0-3)
//   is_jump    out 1   absolute jump within the current 4K page (JMP/JAL)
//   is_halt    out 1   R-type HLT
module instr_decoder
    import fetch_decode_pkg::*;
(
    input  logic [15:0] ir,
    output logic [3:0]  opcode,
    output logic [1:0]  read1,
    output logic [1:0]  read2,
    output logic [5:0]  func,
    output logic [15:0] imm_ext,
    output logic [1:0]  write_reg,
    output logic        wb_elig,
    output logic        is_branch,
    output logic        is_jump,
    output logic        is_halt
);

    assign opcode    = ir[15:12];
    assign read1     = ir[11:10];
    assign read2     = ir[9:8];
    assign func      = ir[5:0];
    assign imm_ext   = sign_ext8(ir[7:0]);
    assign is_branch = (ir[15:14] == 2'b00);
    assign is_jump   = (opcode == OP_JMP) || (opcode == OP_JAL);
    assign is_halt   = (opcode == OP_RTYPE) && (func == FN_HLT);

    always_comb begin
        write_reg = 2'b00;
        wb_elig   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                write_reg = ir[7:6];
                wb_elig   = (func != FN_WWD) && (func != FN_HLT);
            end
            OP_ADI, OP_ORI, OP_LHI: begin
                write_reg = ir[9:8];
                wb_elig   = 1'b1;
            end
            OP_JAL: begin
                write_reg = 2'b10;
                wb_elig   = 1'b1;
            end
            default: begin
                write_reg = 2'b00;
                wb_elig   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/fetch_decode.sv
// fetch_decode
// Multi-cycle instruction fetch / decode sequencer (IDLE -> IF -> ID -> EX -> WB).
// Optional feature macro: INST_COUNT_EN adds the num_inst retired-instruction counter.
//
// state | meaning
// IDLE  | one cycle after reset before the first fetch
// IF    | memory read at PC, waits for input_ready, latches IR
// ID    | IR decoded, register file read ports settle
// EX    | next PC computed (branch_taken sampled here)
// WB    | write-back strobe, next PC committed
// HALT  | HLT executed; absorbing until reset
//
// Ports:
//   clk, reset           clock, async active-high reset
//   data, input_ready    memory read data and its valid
//   branch_taken         ALU branch condition, used in EX
//   address, read_m      fetch address (PC) and read request
//   instruction_fetch    high in IF and ID
//   read1/read2/write_reg/reg_write  register file controls
//   opcode, func, imm_ext            decoded fields
//   pc_next_wb           PC+1 during EX/WB (JAL link value), else 0
//   halted               high in HALT
//   num_inst             (INST_COUNT_EN only) retired instruction count
module fetch_decode
    import fetch_decode_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] data,
    input  logic        input_ready,
    input  logic        branch_taken,
    output logic [15:0] address,
    output logic        read_m,
    output logic        instruction_fetch,
    output logic [1:0]  read1,
    output logic [1:0]  read2,
    output logic [1:0]  write_reg,
    output logic        reg_write,
    output logic [3:0]  opcode,
    output logic [5:0]  func,
    output logic [15:0] imm_ext,
    output logic [15:0] pc_next_wb,
    output logic        halted
`ifdef INST_COUNT_EN
    ,
    output logic [15:0] num_inst
`endif
);

    state_t      state, state_nxt;
    logic [15:0] pc, ir, pc_target, pc_target_d, pc_inc;
    logic        wb_elig, is_branch, is_jump, is_halt;

    instr_decoder u_dec (
        .ir        (ir),
        .opcode    (opcode),
        .read1     (read1),
        .read2     (read2),
        .func      (func),
        .imm_ext   (imm_ext),
        .write_reg (write_reg),
        .wb_elig   (wb_elig),
        .is_branch (is_branch),
        .is_jump   (is_jump),
        .is_halt   (is_halt)
    );

    assign pc_inc  = pc + 16'd1;
    assign address = pc;

    always_comb begin
        pc_target_d = pc_inc;
        if (is_branch && branch_taken)
            pc_target_d = pc_inc + imm_ext;
        else if (is_jump)
            pc_target_d = {pc[15:12], ir[11:0]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            pc        <= 16'h0000;
            ir        <= 16'h0000;
            pc_target <= 16'h0000;
        end else begin
            state <= state_nxt;
            if (state == ST_IF && input_ready)
                ir <= data;
            if (state == ST_EX)
                pc_target <= pc_target_d;
            // WB always leads to IF, so this is the WB->IF commit
            if (state == ST_WB)
                pc <= pc_target;
        end
    end

    always_comb begin
        state_nxt         = state;
        read_m            = 1'b0;
        instruction_fetch = 1'b0;
        reg_write         = 1'b0;
        halted            = 1'b0;
        pc_next_wb        = 16'h0000;
        case (state)
            ST_IDLE: state_nxt = ST_IF;
            ST_IF: begin
                read_m            = 1'b1;
                instruction_fetch = 1'b1;
                if (input_ready)
                    state_nxt = ST_ID;
            end
            ST_ID: begin
                instruction_fetch = 1'b1;
                state_nxt         = ST_EX;
            end
            ST_EX: begin
                pc_next_wb = pc_inc;
                state_nxt  = is_halt ? ST_HALT : ST_WB;
            end
            ST_WB: begin
                pc_next_wb = pc_inc;
                reg_write  = wb_elig;
                state_nxt  = ST_IF;
            end
            ST_HALT: begin
                halted    = 1'b1;
                state_nxt = ST_HALT;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

`ifdef INST_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            num_inst <= 16'h0000;
        else if (state == ST_WB || (state == ST_EX && is_halt))
            num_inst <= num_inst + 16'd1;
    end
`endif

endmodule
